// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit bundle: source/dest register info, branch and
// memory status in; per-register hold/bubble/flush controls out.
interface hazard_ctrl_if;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd_addr;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_hold;
  logic       ifid_hold;
  logic       idex_hold;
  logic       exmem_hold;
  logic       idex_bubble;
  logic       ifid_flush;
  logic       memwb_bubble;

  modport master (
    output id_rs1_addr, id_rs2_addr,
    output id_use_rs1, id_use_rs2,
    output ex_mem_read, ex_rd_addr,
    output ex_branch_taken,
    output mem_req, mem_ready,
    input  pc_hold, ifid_hold,
    input  idex_hold, exmem_hold,
    input  idex_bubble, ifid_flush,
    input  memwb_bubble
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr,
    input  id_use_rs1, id_use_rs2,
    input  ex_mem_read, ex_rd_addr,
    input  ex_branch_taken,
    input  mem_req, mem_ready,
    output pc_hold, ifid_hold,
    output idex_hold, exmem_hold,
    output idex_bubble, ifid_flush,
    output memwb_bubble
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage hazard unit: load-use stall, taken-branch flush, memory-wait
// freeze, registered cause, sticky wait timeout, saturating event counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TMO   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz,
  output logic [1:0]       cause,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lduse_cnt
);

  localparam int unsigned WW =
    (TMO < 2) ? 1 : $clog2(TMO + 1);
  localparam logic [WW-1:0] TMO_V = WW'(TMO);

  typedef enum logic [1:0] {
    C_RUN   = 2'd0,
    C_LDUSE = 2'd1,
    C_MWAIT = 2'd2,
    C_FLUSH = 2'd3
  } cls_e;

  logic             mem_wait;
  logic             load_use;
  logic             rs1_hit;
  logic             rs2_hit;
  cls_e             cls;
  cls_e             cause_q, cause_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] lduse_q, lduse_d;

  assign mem_wait = hz.mem_req && !hz.mem_ready;
  assign rs1_hit  = hz.id_use_rs1
                 && (hz.id_rs1_addr == hz.ex_rd_addr);
  assign rs2_hit  = hz.id_use_rs2
                 && (hz.id_rs2_addr == hz.ex_rd_addr);
  // x0 is never written, so it can't be a load-use source
  assign load_use = hz.ex_mem_read
                 && (hz.ex_rd_addr != 5'd0)
                 && (rs1_hit || rs2_hit);

  // A branch under a memory wait is deferred: EX is frozen,
  // so ex_branch_taken stays up until the wait ends.
  always_comb begin
    cls = C_RUN;
    if (mem_wait)                cls = C_MWAIT;
    else if (hz.ex_branch_taken) cls = C_FLUSH;
    else if (load_use)           cls = C_LDUSE;
  end

  always_comb begin
    hz.pc_hold      = 1'b0;
    hz.ifid_hold    = 1'b0;
    hz.idex_hold    = 1'b0;
    hz.exmem_hold   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.memwb_bubble = 1'b0;
    unique case (cls)
      C_MWAIT: begin
        hz.pc_hold      = 1'b1;
        hz.ifid_hold    = 1'b1;
        hz.idex_hold    = 1'b1;
        hz.exmem_hold   = 1'b1;
        hz.memwb_bubble = 1'b1;
      end
      C_FLUSH: begin
        hz.ifid_flush  = 1'b1;
        hz.idex_bubble = 1'b1;
      end
      C_LDUSE: begin
        hz.pc_hold     = 1'b1;
        hz.ifid_hold   = 1'b1;
        hz.idex_bubble = 1'b1;
      end
      C_RUN: ;
    endcase
  end

  always_comb begin
    cause_d = cls;
    wait_d  = '0;
    if (mem_wait) begin
      wait_d = (wait_q == TMO_V) ? wait_q
                                 : wait_q + 1'b1;
    end
    tmo_d   = tmo_q || (mem_wait && wait_d == TMO_V);
    stall_d = stall_q;
    flush_d = flush_q;
    lduse_d = lduse_q;
    if ((cls == C_MWAIT || cls == C_LDUSE)
        && stall_q != '1)
      stall_d = stall_q + 1'b1;
    if (cls == C_FLUSH && flush_q != '1)
      flush_d = flush_q + 1'b1;
    if (cls == C_LDUSE && lduse_q != '1)
      lduse_d = lduse_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= C_RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
      lduse_q <= '0;
    end else begin
      cause_q <= cause_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      lduse_q <= lduse_d;
    end
  end

  assign cause       = cause_q;
  assign mem_timeout = tmo_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign lduse_cnt   = lduse_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=2, TMO=4 to reach saturation
// and timeout quickly).
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] cause;
  logic       mem_timeout;
  logic [1:0] stall_cnt;
  logic [1:0] flush_cnt;
  logic [1:0] lduse_cnt;
  int         pass_n;
  int         total_n;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.CNT_W(2), .TMO(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hz          (hz.slave),
    .cause       (cause),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .lduse_cnt   (lduse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem holds, idex_bubble, ifid_flush, memwb_bubble}
  logic [6:0] hzv;
  assign hzv = {hz.pc_hold, hz.ifid_hold,
                hz.idex_hold, hz.exmem_hold,
                hz.idex_bubble, hz.ifid_flush,
                hz.memwb_bubble};

  localparam logic [6:0] H_RUN = 7'b0000000;
  localparam logic [6:0] H_LDU = 7'b1100100;
  localparam logic [6:0] H_MW  = 7'b1111001;
  localparam logic [6:0] H_FL  = 7'b0000110;

  task automatic idle();
    hz.id_rs1_addr     = 5'd0;
    hz.id_rs2_addr     = 5'd0;
    hz.id_use_rs1      = 1'b0;
    hz.id_use_rs2      = 1'b0;
    hz.ex_mem_read     = 1'b0;
    hz.ex_rd_addr      = 5'd0;
    hz.ex_branch_taken = 1'b0;
    hz.mem_req         = 1'b0;
    hz.mem_ready       = 1'b0;
  endtask

  task automatic set_lduse(input logic [4:0] rd);
    hz.ex_mem_read = 1'b1;
    hz.ex_rd_addr  = rd;
    hz.id_rs1_addr = 5'd5;
    hz.id_use_rs1  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    hz.mem_req = 1'b1;
    #3;
    total_n++;
    if ({cause, mem_timeout, stall_cnt, flush_cnt, lduse_cnt} !== 9'd0)
      $display("FAIL reset_state got %b want 0",
               {cause, mem_timeout, stall_cnt, flush_cnt, lduse_cnt});
    else pass_n++;
    total_n++;
    if (hzv !== H_MW)
      $display("FAIL reset_comb got %b want %b", hzv, H_MW);
    else pass_n++;
    tick();
    total_n++;
    if (cause !== 2'd0 || stall_cnt !== 2'd0)
      $display("FAIL reset_hold got cause=%0d stall=%0d want 0 0",
               cause, stall_cnt);
    else pass_n++;
    do_reset();
  endtask

  task automatic test_lduse();
    do_reset();
    set_lduse(5'd5);
    #1;
    total_n++;
    if (hzv !== H_LDU)
      $display("FAIL lduse_comb got %b want %b", hzv, H_LDU);
    else pass_n++;
    tick();
    idle();
    total_n++;
    if ({cause, lduse_cnt, stall_cnt, flush_cnt} !== {2'd1, 2'd1, 2'd1, 2'd0})
      $display("FAIL lduse_regs got c=%0d l=%0d s=%0d f=%0d want 1 1 1 0",
               cause, lduse_cnt, stall_cnt, flush_cnt);
    else pass_n++;
    tick();
    total_n++;
    if (cause !== 2'd0)
      $display("FAIL lduse_run got %0d want 0", cause);
    else pass_n++;
    // rs2 path
    hz.ex_mem_read = 1'b1;
    hz.ex_rd_addr  = 5'd9;
    hz.id_rs2_addr = 5'd9;
    hz.id_use_rs2  = 1'b1;
    #1;
    total_n++;
    if (hzv !== H_LDU)
      $display("FAIL lduse_rs2 got %b want %b", hzv, H_LDU);
    else pass_n++;
    tick();
    idle();
    total_n++;
    if (lduse_cnt !== 2'd2)
      $display("FAIL lduse_rs2_cnt got %0d want 2", lduse_cnt);
    else pass_n++;
  endtask

  task automatic test_no_lduse();
    do_reset();
    set_lduse(5'd0);
    hz.id_rs1_addr = 5'd0;
    #1;
    total_n++;
    if (hzv !== H_RUN)
      $display("FAIL x0_comb got %b want %b", hzv, H_RUN);
    else pass_n++;
    tick();
    total_n++;
    if ({cause, lduse_cnt, stall_cnt} !== 6'd0)
      $display("FAIL x0_regs got c=%0d l=%0d s=%0d want 0 0 0",
               cause, lduse_cnt, stall_cnt);
    else pass_n++;
    set_lduse(5'd5);
    hz.id_use_rs1 = 1'b0;
    #1;
    total_n++;
    if (hzv !== H_RUN)
      $display("FAIL nouse_comb got %b want %b", hzv, H_RUN);
    else pass_n++;
    tick();
    idle();
    total_n++;
    if ({cause, lduse_cnt, stall_cnt} !== 6'd0)
      $display("FAIL nouse_regs got c=%0d l=%0d s=%0d want 0 0 0",
               cause, lduse_cnt, stall_cnt);
    else pass_n++;
  endtask

  task automatic test_mwait_flush();
    do_reset();
    set_lduse(5'd5);
    hz.ex_branch_taken = 1'b1;
    hz.mem_req   = 1'b1;
    hz.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_n++;
      if (hzv !== H_MW)
        $display("FAIL mwait_comb[%0d] got %b want %b", i, hzv, H_MW);
      else pass_n++;
      tick();
      total_n++;
      if (cause !== 2'd2)
        $display("FAIL mwait_cause[%0d] got %0d want 2", i, cause);
      else pass_n++;
    end
    hz.mem_ready = 1'b1;
    #1;
    total_n++;
    if (hzv !== H_FL)
      $display("FAIL flush_comb got %b want %b", hzv, H_FL);
    else pass_n++;
    tick();
    idle();
    total_n++;
    if ({cause, stall_cnt, flush_cnt, lduse_cnt} !== {2'd3, 2'd3, 2'd1, 2'd0})
      $display("FAIL flush_regs got c=%0d s=%0d f=%0d l=%0d want 3 3 1 0",
               cause, stall_cnt, flush_cnt, lduse_cnt);
    else pass_n++;
  endtask

  task automatic test_timeout();
    do_reset();
    hz.mem_req   = 1'b1;
    hz.mem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total_n++;
      if (mem_timeout !== (k >= 4))
        $display("FAIL tmo_edge[%0d] got %b want %b",
                 k, mem_timeout, (k >= 4));
      else pass_n++;
    end
    hz.mem_ready = 1'b1;
    tick();
    tick();
    idle();
    total_n++;
    if (mem_timeout !== 1'b1 || cause !== 2'd0)
      $display("FAIL tmo_sticky got t=%b c=%0d want 1 0",
               mem_timeout, cause);
    else pass_n++;
  endtask

  task automatic test_saturate();
    do_reset();
    set_lduse(5'd5);
    for (int i = 0; i < 5; i++) tick();
    total_n++;
    if (lduse_cnt !== 2'd3 || stall_cnt !== 2'd3)
      $display("FAIL lduse_sat got l=%0d s=%0d want 3 3",
               lduse_cnt, stall_cnt);
    else pass_n++;
    idle();
    hz.ex_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    total_n++;
    if (flush_cnt !== 2'd3 || lduse_cnt !== 2'd3)
      $display("FAIL flush_sat got f=%0d l=%0d want 3 3",
               flush_cnt, lduse_cnt);
    else pass_n++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hz.mem_req   = 1'b1;
    hz.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total_n++;
    if (mem_timeout !== 1'b1 || cause !== 2'd2)
      $display("FAIL prewait got t=%b c=%0d want 1 2",
               mem_timeout, cause);
    else pass_n++;
    #1;
    rst_n = 1'b0;
    #1;
    total_n++;
    if ({cause, mem_timeout, stall_cnt} !== 5'd0)
      $display("FAIL async_clr got c=%0d t=%b s=%0d want 0 0 0",
               cause, mem_timeout, stall_cnt);
    else pass_n++;
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total_n++;
      if (mem_timeout !== (k >= 4))
        $display("FAIL rewait[%0d] got %b want %b",
                 k, mem_timeout, (k >= 4));
      else pass_n++;
    end
    idle();
  endtask

  initial begin
    pass_n  = 0;
    total_n = 0;
    rst_n   = 1'b0;
    idle();
    test_reset();
    test_lduse();
    test_no_lduse();
    test_mwait_flush();
    test_timeout();
    test_saturate();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
